display_page_sequencer: RTL and testbench

Controller that owns the 8-digit dashboard display and decides what it shows. It arbitrates between three requesters: the normal drive view, the OBD diagnostic pages and engine alerts. It rotates OBD pages on a timer or button press and pre-empts any page with a blinking alert. It sits between the vehicle-state registers and the display unit, and hands it two registered 14-bit values plus blank controls.

---
 rtl/display_pkg.sv | 30 +++
 rtl/ms_down_timer.sv | 33 +++
 rtl/display_page_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_display_page_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the dashboard display page sequencer:
// FSM state encoding, page_id values and alert_code values.
package display_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_OBD_RT = 2'd1,
      ST_OBD_FS = 2'd2,
      ST_ALERT  = 2'd3
   } state_e;

   localparam logic [2:0] PG_NORMAL = 3'd0;
   localparam logic [2:0] PG_OBD_RT = 3'd1;
   localparam logic [2:0] PG_OBD_FS = 3'd2;
   localparam logic [2:0] PG_ALERT  = 3'd3;

   localparam logic [1:0] AC_NONE = 2'd0;
   localparam logic [1:0] AC_TEMP = 2'd1;
   localparam logic [1:0] AC_FUEL = 2'd2;

   function automatic logic [2:0] page_of(input state_e s);
      case (s)
         ST_OBD_RT: page_of = PG_OBD_RT;
         ST_OBD_FS: page_of = PG_OBD_FS;
         ST_ALERT:  page_of = PG_ALERT;
         default:   page_of = PG_NORMAL;
      endcase
   endfunction

endpackage

// File: rtl/ms_down_timer.sv
// Loadable millisecond down counter: counts tick_i strobes from PERIOD to 0,
// pulses expire_o on the tick that reaches 0 and reloads itself.
module ms_down_timer #(
   parameter int unsigned PERIOD = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic tick_i,
   output logic expire_o
);

   localparam int unsigned W = $clog2(PERIOD + 1);
   localparam logic [W-1:0] RELOAD = W'(PERIOD);

   logic [W-1:0] cnt_q, cnt_d;

   assign expire_o = tick_i && (cnt_q == W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_i || expire_o) cnt_d = RELOAD;
      else if (tick_i)        cnt_d = cnt_q - W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= RELOAD;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/display_page_sequencer.sv
// Dashboard display arbiter: drive view, rotating OBD pages and blinking
// engine alerts. Alert logic is built only when DISPLAY_ALERT_EN is defined.
module display_page_sequencer
   import display_pkg::*;
#(
   parameter int unsigned PAGE_MS   = 2000,
   parameter int unsigned ALERT_MS  = 3000,
   parameter int unsigned BLINK_MS  = 250,
   parameter int unsigned FUEL_LOW  = 15,
   parameter int unsigned TEMP_HIGH = 110,
   parameter int unsigned HYST      = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_ms,
   input  logic        obd_mode_sw,
   input  logic        btn_next,
   input  logic [13:0] rpm,
   input  logic [7:0]  speed,
   input  logic [7:0]  fuel,
   input  logic [7:0]  temp,
   input  logic [7:0]  accel,
   output logic [13:0] left_val,
   output logic [13:0] right_val,
   output logic [2:0]  page_id,
   output logic        blank_left,
   output logic        blank_right,
   output logic        alert_active,
   output logic [1:0]  alert_code
);

   if (PAGE_MS < 1 || ALERT_MS < 1 || BLINK_MS < 1 || TEMP_HIGH < HYST ||
       TEMP_HIGH > 254 || FUEL_LOW + HYST > 255) begin : g_bad_params
      $error("display_page_sequencer: inconsistent timer or threshold parameters");
   end

   state_e      state_q, state_d;
   logic        sw_q;
   logic        page_load, page_en, page_exp;
   logic [2:0]  page_id_d;
   logic [13:0] left_d, right_d;
   logic        blank_l_d, blank_r_d, active_d;
   logic [1:0]  code_out_d;

   // Page timer only runs while an OBD page is showing, so it freezes in ALERT.
   assign page_en = tick_ms && (state_q == ST_OBD_RT || state_q == ST_OBD_FS);

   ms_down_timer #(.PERIOD(PAGE_MS)) u_page_tmr (
      .clk(clk), .rst(rst), .load_i(page_load), .tick_i(page_en), .expire_o(page_exp)
   );

`ifdef DISPLAY_ALERT_EN
   localparam logic [7:0] TEMP_SET = 8'(TEMP_HIGH);
   localparam logic [7:0] TEMP_CLR = 8'(TEMP_HIGH - HYST);
   localparam logic [7:0] FUEL_SET = 8'(FUEL_LOW);
   localparam logic [7:0] FUEL_CLR = 8'(FUEL_LOW + HYST);

   logic       temp_hi_q, temp_hi_d, temp_prev_q, temp_set;
   logic       fuel_lo_q, fuel_lo_d, fuel_prev_q, fuel_set;
   logic       pend_t_q, pend_t_d, pend_f_q, pend_f_d;
   state_e     saved_q, saved_d;
   logic [1:0] code_q, code_d;
   logic       vis_q, vis_d;
   logic       alert_load, alert_en, alert_exp, blink_exp;

   assign alert_en = tick_ms && (state_q == ST_ALERT);

   ms_down_timer #(.PERIOD(ALERT_MS)) u_alert_tmr (
      .clk(clk), .rst(rst), .load_i(alert_load), .tick_i(alert_en), .expire_o(alert_exp)
   );
   ms_down_timer #(.PERIOD(BLINK_MS)) u_blink_tmr (
      .clk(clk), .rst(rst), .load_i(alert_load), .tick_i(alert_en), .expire_o(blink_exp)
   );

   // Hysteresis flags; a request is the registered flag's rising edge.
   always_comb begin
      temp_hi_d = temp_hi_q;
      fuel_lo_d = fuel_lo_q;
      if (temp > TEMP_SET)       temp_hi_d = 1'b1;
      else if (temp <= TEMP_CLR) temp_hi_d = 1'b0;
      if (fuel < FUEL_SET)       fuel_lo_d = 1'b1;
      else if (fuel >= FUEL_CLR) fuel_lo_d = 1'b0;
   end

   assign temp_set = temp_hi_q && !temp_prev_q;
   assign fuel_set = fuel_lo_q && !fuel_prev_q;
   assign vis_d    = alert_load ? 1'b1 : (blink_exp ? !vis_q : vis_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         temp_hi_q   <= 1'b0;
         temp_prev_q <= 1'b0;
         fuel_lo_q   <= 1'b0;
         fuel_prev_q <= 1'b0;
         pend_t_q    <= 1'b0;
         pend_f_q    <= 1'b0;
         saved_q     <= ST_NORMAL;
         code_q      <= AC_NONE;
         vis_q       <= 1'b1;
      end else begin
         temp_hi_q   <= temp_hi_d;
         temp_prev_q <= temp_hi_q;
         fuel_lo_q   <= fuel_lo_d;
         fuel_prev_q <= fuel_lo_q;
         pend_t_q    <= pend_t_d;
         pend_f_q    <= pend_f_d;
         saved_q     <= saved_d;
         code_q      <= code_d;
         vis_q       <= vis_d;
      end
   end
`endif

   // Next-state logic.
   // NOTE: every variable written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      page_load = 1'b0;
`ifdef DISPLAY_ALERT_EN
      saved_d    = saved_q;
      code_d     = code_q;
      alert_load = 1'b0;
      pend_t_d   = pend_t_q || temp_set;
      pend_f_d   = pend_f_q || fuel_set;
`endif
      if (state_q != ST_ALERT) begin
         if (!obd_mode_sw) begin
            state_d = ST_NORMAL;
         end else if (state_q == ST_NORMAL || !sw_q) begin
            state_d   = ST_OBD_RT;
            page_load = 1'b1;
         end else if (page_exp || btn_next) begin
            state_d   = (state_q == ST_OBD_RT) ? ST_OBD_FS : ST_OBD_RT;
            page_load = 1'b1;
         end
`ifdef DISPLAY_ALERT_EN
         if (pend_t_d || pend_f_d) begin
            saved_d    = state_d;
            state_d    = ST_ALERT;
            alert_load = 1'b1;
         end
      end else if (alert_exp || btn_next) begin
         if (pend_t_d || pend_f_d) begin
            alert_load = 1'b1;
         end else begin
            code_d = AC_NONE;
            if (!obd_mode_sw) begin
               state_d = ST_NORMAL;
            end else if (saved_q == ST_NORMAL) begin
               state_d   = ST_OBD_RT;
               page_load = 1'b1;
            end else begin
               state_d = saved_q;
            end
         end
      end
      // Temperature always wins; the other request stays pending.
      if (alert_load) begin
         if (pend_t_d) begin
            code_d   = AC_TEMP;
            pend_t_d = 1'b0;
         end else begin
            code_d   = AC_FUEL;
            pend_f_d = 1'b0;
         end
`endif
      end
   end

   // Output values are derived from the next state so they land one cycle after the cause.
   always_comb begin
      page_id_d  = page_of(state_d);
      left_d     = '0;
      right_d    = '0;
      blank_l_d  = 1'b0;
      blank_r_d  = 1'b0;
      active_d   = 1'b0;
      code_out_d = AC_NONE;
      case (state_d)
         ST_NORMAL: begin
            left_d  = 14'(accel);
            right_d = 14'(speed);
         end
         ST_OBD_RT: begin
            left_d  = rpm;
            right_d = 14'(temp);
         end
         ST_OBD_FS: begin
            left_d  = 14'(fuel);
            right_d = 14'(speed);
         end
         default: begin
`ifdef DISPLAY_ALERT_EN
            active_d   = 1'b1;
            code_out_d = code_d;
            blank_r_d  = !vis_d;
            if (code_d == AC_FUEL) begin
               blank_l_d = 1'b1;
               right_d   = 14'(fuel);
            end else begin
               left_d  = rpm;
               right_d = 14'(temp);
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_NORMAL;
         sw_q         <= 1'b0;
         page_id      <= PG_NORMAL;
         left_val     <= '0;
         right_val    <= '0;
         blank_left   <= 1'b0;
         blank_right  <= 1'b0;
         alert_active <= 1'b0;
         alert_code   <= AC_NONE;
      end else begin
         state_q      <= state_d;
         sw_q         <= obd_mode_sw;
         page_id      <= page_id_d;
         left_val     <= left_d;
         right_val    <= right_d;
         blank_left   <= blank_l_d;
         blank_right  <= blank_r_d;
         alert_active <= active_d;
         alert_code   <= code_out_d;
      end
   end

endmodule

// File: tb/tb_display_page_sequencer.sv
// Directed bench for display_page_sequencer: vector table for mode selection,
// hand-written sequences for rotation timing, alerts and reset.
module tb_display_page_sequencer;
   import display_pkg::*;

   logic        clk = 1'b0;
   logic        rst, tick_ms, obd_mode_sw, btn_next;
   logic [13:0] rpm;
   logic [7:0]  speed, fuel, temp, accel;
   logic [13:0] left_val, right_val;
   logic [2:0]  page_id;
   logic        blank_left, blank_right, alert_active;
   logic [1:0]  alert_code;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   display_page_sequencer dut (
      .clk(clk), .rst(rst), .tick_ms(tick_ms), .obd_mode_sw(obd_mode_sw),
      .btn_next(btn_next), .rpm(rpm), .speed(speed), .fuel(fuel), .temp(temp),
      .accel(accel), .left_val(left_val), .right_val(right_val), .page_id(page_id),
      .blank_left(blank_left), .blank_right(blank_right),
      .alert_active(alert_active), .alert_code(alert_code)
   );

   typedef struct {
      logic        obd;
      logic        btn;
      logic [13:0] rpm;
      logic [7:0]  accel, speed, fuel, temp;
      logic [2:0]  pg;
      logic [13:0] l, r;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_disp(input string tag, input int pg, input int l, input int r,
                             input int bl, input int br, input int act, input int code);
      check($sformatf("%s.page_id", tag),      32'(page_id),      pg);
      check($sformatf("%s.left_val", tag),     32'(left_val),     l);
      check($sformatf("%s.right_val", tag),    32'(right_val),    r);
      check($sformatf("%s.blank_left", tag),   32'(blank_left),   bl);
      check($sformatf("%s.blank_right", tag),  32'(blank_right),  br);
      check($sformatf("%s.alert_active", tag), 32'(alert_active), act);
      check($sformatf("%s.alert_code", tag),   32'(alert_code),   code);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      tick_ms = 1'b1;
      repeat (n) cyc();
      tick_ms = 1'b0;
   endtask

   initial begin
      vecs[0] = '{obd:1'b0, btn:1'b0, rpm:14'd0,     accel:8'd40,  speed:8'd88,  fuel:8'd50, temp:8'd90,  pg:3'd0, l:14'd40,    r:14'd88};
      vecs[1] = '{obd:1'b0, btn:1'b1, rpm:14'd0,     accel:8'd255, speed:8'd0,   fuel:8'd50, temp:8'd90,  pg:3'd0, l:14'd255,   r:14'd0};
      vecs[2] = '{obd:1'b1, btn:1'b0, rpm:14'd3500,  accel:8'd255, speed:8'd0,   fuel:8'd50, temp:8'd90,  pg:3'd1, l:14'd3500,  r:14'd90};
      vecs[3] = '{obd:1'b1, btn:1'b1, rpm:14'd3500,  accel:8'd255, speed:8'd60,  fuel:8'd50, temp:8'd90,  pg:3'd2, l:14'd50,    r:14'd60};
      vecs[4] = '{obd:1'b1, btn:1'b1, rpm:14'd9999,  accel:8'd255, speed:8'd60,  fuel:8'd50, temp:8'd90,  pg:3'd1, l:14'd9999,  r:14'd90};
      vecs[5] = '{obd:1'b1, btn:1'b0, rpm:14'd16383, accel:8'd255, speed:8'd60,  fuel:8'd50, temp:8'd100, pg:3'd1, l:14'd16383, r:14'd100};
      vecs[6] = '{obd:1'b0, btn:1'b0, rpm:14'd16383, accel:8'd7,   speed:8'd200, fuel:8'd50, temp:8'd100, pg:3'd0, l:14'd7,     r:14'd200};
      vecs[7] = '{obd:1'b1, btn:1'b0, rpm:14'd1234,  accel:8'd7,   speed:8'd200, fuel:8'd21, temp:8'd104, pg:3'd1, l:14'd1234,  r:14'd104};

      rst = 1'b1; tick_ms = 1'b0; obd_mode_sw = 1'b0; btn_next = 1'b0;
      rpm = '0; speed = 8'd88; fuel = 8'd50; temp = 8'd90; accel = 8'd40;
      cyc();
      cyc();
      check_disp("reset", 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Mode selection and manual page stepping
      for (int i = 0; i < 8; i++) begin
         obd_mode_sw = vecs[i].obd; btn_next = vecs[i].btn; rpm = vecs[i].rpm;
         accel = vecs[i].accel; speed = vecs[i].speed; fuel = vecs[i].fuel; temp = vecs[i].temp;
         cyc();
         btn_next = 1'b0;
         check_disp($sformatf("vec%0d", i), vecs[i].pg, vecs[i].l, vecs[i].r, 0, 0, 0, 0);
      end

      // Auto-rotation: page timer was loaded by the rising edge in vec7
      ticks(1999);
      check("rot.hold_rt", 32'(page_id), 1);
      ticks(1);
      check("rot.expire_fs", 32'(page_id), 2);
      ticks(1999);
      check("rot.hold_fs", 32'(page_id), 2);
      tick_ms = 1'b1; btn_next = 1'b1;
      cyc();
      tick_ms = 1'b0; btn_next = 1'b0;
      check("rot.btn_on_expiry_once", 32'(page_id), 1);
      ticks(1999);
      check("rot.reload_hold", 32'(page_id), 1);
      ticks(1);
      check("rot.reload_expire", 32'(page_id), 2);

`ifdef DISPLAY_ALERT_EN
      // Over-temperature alert from OBD_FS
      temp = 8'd100;
      cyc();
      temp = 8'd111;
      cyc();
      check("ot.flag_cycle", 32'(page_id), 2);
      cyc();
      check_disp("ot.enter", 3, 1234, 111, 0, 0, 1, 1);
      ticks(249);
      check("ot.blink_vis", 32'(blank_right), 0);
      ticks(1);
      check("ot.blink_off", 32'(blank_right), 1);
      ticks(249);
      check("ot.blink_off_hold", 32'(blank_right), 1);
      ticks(1);
      check("ot.blink_on", 32'(blank_right), 0);
      ticks(2499);
      check("ot.hold", 32'(page_id), 3);
      ticks(1);
      check_disp("ot.exit", 2, 21, 200, 0, 0, 0, 0);
      ticks(1999);
      check("ot.frozen_hold", 32'(page_id), 2);
      ticks(1);
      check("ot.frozen_expire", 32'(page_id), 1);

      // Simultaneous temperature and fuel alerts
      temp = 8'd100; fuel = 8'd20;
      cyc();
      cyc();
      temp = 8'd115; fuel = 8'd14;
      cyc();
      check("dual.flag_cycle", 32'(page_id), 1);
      cyc();
      check_disp("dual.temp_first", 3, 1234, 115, 0, 0, 1, 1);
      btn_next = 1'b1;
      cyc();
      btn_next = 1'b0;
      check_disp("dual.fuel_next", 3, 0, 14, 1, 0, 1, 2);
      btn_next = 1'b1;
      cyc();
      btn_next = 1'b0;
      check_disp("dual.restore", 1, 1234, 115, 0, 0, 0, 0);
      fuel = 8'd19;
      repeat (3) cyc();
      check("fuel.hyst_hold", 32'(alert_active), 0);
      fuel = 8'd14;
      repeat (3) cyc();
      check("fuel.no_recur", 32'(alert_active), 0);
      fuel = 8'd20;
      cyc();
      cyc();
      fuel = 8'd14;
      cyc();
      check("fuel.rearm_flag_cycle", 32'(page_id), 1);
      cyc();
      check_disp("fuel.rearm", 3, 0, 14, 1, 0, 1, 2);

      // Mode switched off during alert: exit lands in NORMAL
      obd_mode_sw = 1'b0;
      cyc();
      check("modeoff.alert_holds", 32'(page_id), 3);
      ticks(2999);
      check("modeoff.hold", 32'(page_id), 3);
      ticks(1);
      check_disp("modeoff.exit", 0, 7, 200, 0, 0, 0, 0);

      // Set up a live alert with the right half blanked, then reset it
      obd_mode_sw = 1'b1;
      cyc();
      check("pre_rst.obd", 32'(page_id), 1);
      temp = 8'd100;
      cyc();
      cyc();
      temp = 8'd111;
      cyc();
      cyc();
      check_disp("pre_rst.alert", 3, 1234, 111, 0, 0, 1, 1);
      ticks(250);
      check("pre_rst.blank", 32'(blank_right), 1);
`else
      // Without alert logic the thresholds do nothing and btn_next only pages
      temp = 8'd120; fuel = 8'd5;
      cyc();
      cyc();
      check_disp("noalert.levels", 2, 5, 200, 0, 0, 0, 0);
      btn_next = 1'b1;
      cyc();
      btn_next = 1'b0;
      check_disp("noalert.btn", 1, 1234, 120, 0, 0, 0, 0);
      ticks(500);
      check("noalert.midrot", 32'(page_id), 1);
`endif

      temp = 8'd90; fuel = 8'd50;
      tick_ms = 1'b1; btn_next = 1'b1; rst = 1'b1;
      cyc();
      tick_ms = 1'b0; btn_next = 1'b0;
      check_disp("rst.mid", 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      cyc();
      check_disp("rst.release", 1, 1234, 90, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
